// File: rtl/operand_fetch.sv
// rtl/operand_fetch.sv - register file read, busy scoreboard for RAW/WAW hazards, operand register
// Optional same-cycle writeback bypass enabled by defining OPFETCH_BYPASS_EN.
module operand_fetch #(
  parameter int DW = 8,
  parameter int AW = 2,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] in_rs1,
  input  logic [AW-1:0] in_rs2,
  input  logic [AW-1:0] in_rd,
  input  logic          in_rd_wen,
  input  logic [TW-1:0] in_op,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  input  logic          wb_wen,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_a,
  output logic [DW-1:0] out_b,
  output logic [AW-1:0] out_rd,
  output logic          out_rd_wen,
  output logic [TW-1:0] out_op
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] busy;
  logic [NR-1:0] busy_next;
  logic          byp1;
  logic          byp2;
  logic          rd_wb_hit;
  logic          hazard;
  logic          accept;
  logic [DW-1:0] opnd_a;
  logic [DW-1:0] opnd_b;

  assign rf_raddr1 = in_rs1;
  assign rf_raddr2 = in_rs2;

  assign rd_wb_hit = wb_wen && (wb_addr == in_rd);

`ifdef OPFETCH_BYPASS_EN
  // Register file writes only land at the edge, so a matching writeback is forwarded here.
  assign byp1   = wb_wen && (wb_addr == in_rs1);
  assign byp2   = wb_wen && (wb_addr == in_rs2);
  assign opnd_a = byp1 ? wb_data : rf_rdata1;
  assign opnd_b = byp2 ? wb_data : rf_rdata2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp1   = 1'b0;
  assign byp2   = 1'b0;
  assign opnd_a = rf_rdata1;
  assign opnd_b = rf_rdata2;
`endif

  // Source checks use pre-accept busy, so rs == rd of one instruction never self-stalls.
  assign hazard = (busy[in_rs1] && !byp1)
               || (busy[in_rs2] && !byp2)
               || (in_rd_wen && busy[in_rd] && !rd_wb_hit);

  assign in_ready = !reset && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Clear from writeback first, then set from accept so a same-register set wins.
  always_comb begin
    busy_next = busy;
    if (wb_wen) begin
      busy_next[wb_addr] = 1'b0;
    end
    if (accept && in_rd_wen) begin
      busy_next[in_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= '0;
      out_valid  <= 1'b0;
      out_a      <= '0;
      out_b      <= '0;
      out_rd     <= '0;
      out_rd_wen <= 1'b0;
      out_op     <= '0;
    end else begin
      busy <= busy_next;
      if (accept) begin
        out_valid  <= 1'b1;
        out_a      <= opnd_a;
        out_b      <= opnd_b;
        out_rd     <= in_rd;
        out_rd_wen <= in_rd_wen;
        out_op     <= in_op;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// tb/tb_operand_fetch.sv - vector table, corner sequences and randomized model check for operand_fetch
module tb_operand_fetch;
  localparam int DW = 8;
  localparam int AW = 2;
  localparam int TW = 4;
  localparam int NR = 4;
`ifdef OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_rd_wen;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic [TW-1:0] in_op;
  logic [AW-1:0] rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic wb_wen;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic out_valid, out_ready, out_rd_wen;
  logic [DW-1:0] out_a, out_b;
  logic [AW-1:0] out_rd;
  logic [TW-1:0] out_op;

  logic tbl_mode;
  logic [DW-1:0] t_rd1, t_rd2;
  logic [DW-1:0] rf [NR];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign rf_rdata1 = tbl_mode ? t_rd1 : rf[rf_raddr1];
  assign rf_rdata2 = tbl_mode ? t_rd2 : rf[rf_raddr2];

  operand_fetch #(.DW(DW), .AW(AW), .TW(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen), .in_op(in_op),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_op(out_op)
  );

  typedef struct {
    logic v; logic [1:0] s1; logic [1:0] s2; logic [1:0] d; logic dw; logic [3:0] op;
    logic [7:0] r1; logic [7:0] r2; logic ww; logic [1:0] wa; logic [7:0] wd; logic ordy;
    logic e_ir; logic e_ov; logic [7:0] e_a; logic [7:0] e_b; logic [3:0] e_op;
  } vec_t;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [1:0] rd; logic rdw; logic [3:0] op; } ent_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put(input logic v, input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] d,
                     input logic dw, input logic [3:0] op, input logic [7:0] r1, input logic [7:0] r2,
                     input logic ww, input logic [1:0] wa, input logic [7:0] wd, input logic ordy);
    @(negedge clk);
    in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_wen = dw; in_op = op;
    t_rd1 = r1; t_rd2 = r2; wb_wen = ww; wb_addr = wa; wb_data = wd; out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; wb_wen = 1'b0;
    tick();
    tick();
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[10];
  ent_t outq[$];
  ent_t held;
  ent_t e;
  logic [NR-1:0] mbusy;
  int k;
  logic b1, b2, hz, exp_ir, acc;

  initial begin
    reset = 1'b1; tbl_mode = 1'b1;
    in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_wen = 0; in_op = 0;
    t_rd1 = 0; t_rd2 = 0; wb_wen = 0; wb_addr = 0; wb_data = 0; out_ready = 1;
    for (int i = 0; i < NR; i++) rf[i] = 8'h00;
    tick(); tick();
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_a", out_a, 0);
    chk("reset_out_b", out_b, 0);
    chk("reset_out_rd", {out_rd, out_rd_wen}, 0);
    chk("reset_out_op", out_op, 0);
    @(negedge clk);
    reset = 1'b0;

    // v s1 s2 d dw op r1 r2 ww wa wd ordy | ir ov a b op
    vecs[0] = '{1,1,2,0,0,4'h5,8'h11,8'h22,0,0,8'h00,1, 1,1,8'h11,8'h22,4'h5};
    vecs[1] = '{1,0,0,3,1,4'h6,8'h33,8'h44,0,0,8'h00,1, 1,1,8'h33,8'h44,4'h6};
    vecs[2] = '{1,3,0,0,0,4'h7,8'h99,8'h99,0,0,8'h00,1, 0,0,8'h33,8'h44,4'h6};
    vecs[3] = '{1,0,3,0,0,4'h7,8'h99,8'h99,0,0,8'h00,1, 0,0,8'h33,8'h44,4'h6};
    vecs[4] = '{1,0,1,3,1,4'h8,8'h99,8'h99,0,0,8'h00,1, 0,0,8'h33,8'h44,4'h6};
    vecs[5] = '{1,0,1,3,0,4'h9,8'ha1,8'hb1,0,0,8'h00,1, 1,1,8'ha1,8'hb1,4'h9};
    vecs[6] = '{0,0,0,0,0,4'h0,8'h00,8'h00,1,3,8'h5a,1, 1,0,8'ha1,8'hb1,4'h9};
    vecs[7] = '{1,3,3,2,1,4'hc,8'h5a,8'h5a,0,0,8'h00,1, 1,1,8'h5a,8'h5a,4'hc};
    vecs[8] = '{1,0,0,0,0,4'hd,8'h01,8'h02,0,0,8'h00,0, 0,1,8'h5a,8'h5a,4'hc};
    vecs[9] = '{1,0,0,0,0,4'hd,8'h01,8'h02,0,0,8'h00,1, 1,1,8'h01,8'h02,4'hd};
    for (int i = 0; i < 10; i++) begin
      put(vecs[i].v, vecs[i].s1, vecs[i].s2, vecs[i].d, vecs[i].dw, vecs[i].op,
          vecs[i].r1, vecs[i].r2, vecs[i].ww, vecs[i].wa, vecs[i].wd, vecs[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("vec%0d_raddr", i), {rf_raddr1, rf_raddr2}, {vecs[i].s1, vecs[i].s2});
      tick();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("vec%0d_out_ab", i), {out_a, out_b}, {vecs[i].e_a, vecs[i].e_b});
      chk($sformatf("vec%0d_out_op", i), out_op, vecs[i].e_op);
    end

    // RAW on rd=3 resolved by writeback of 0x5A
    do_reset();
    put(1,0,0,3,1,4'h1,8'h00,8'h00,0,0,8'h00,1);
    chk("raw_issue_ready", in_ready, 1);
    tick();
    put(1,3,3,0,0,4'h2,8'h77,8'h77,0,0,8'h00,1);
    chk("raw_stall", in_ready, 0);
    tick();
    k = 9;
    for (int c = 0; c < 3; c++) begin
      if (c == 0) put(1,3,3,0,0,4'h2,8'h77,8'h77,1,3,8'h5a,1);
      else        put(1,3,3,0,0,4'h2,8'h5a,8'h5a,0,0,8'h00,1);
      if (in_ready) begin
        k = c;
        tick();
        break;
      end
      tick();
    end
    chk("raw_issue_cycle", k, BYP ? 0 : 1);
    chk("raw_out_valid", out_valid, 1);
    chk("raw_out_ab", {out_a, out_b}, 16'h5a5a);

    // execute stall: outputs frozen for three cycles
    for (int c = 0; c < 3; c++) begin
      put(1,0,0,0,0,4'he,8'h10,8'h20,0,0,8'h00,0);
      chk("stall_in_ready", in_ready, 0);
      tick();
      chk("stall_out_valid", out_valid, 1);
      chk("stall_out_hold", {out_a, out_b, out_op}, {8'h5a, 8'h5a, 4'h2});
    end
    put(1,0,0,0,0,4'he,8'h10,8'h20,0,0,8'h00,1);
    chk("unstall_in_ready", in_ready, 1);
    tick();
    chk("unstall_out", {out_a, out_b, out_op}, {8'h10, 8'h20, 4'he});

    // WAW on rd=2 and set-wins when accept coincides with the clearing writeback
    put(1,0,0,2,1,4'h3,8'h00,8'h00,0,0,8'h00,1); tick();
    put(1,0,1,2,1,4'h4,8'h00,8'h00,0,0,8'h00,1);
    chk("waw_stall", in_ready, 0);
    tick();
    put(1,0,1,2,1,4'h4,8'h00,8'h00,1,2,8'h66,1);
    chk("waw_accept_on_wb", in_ready, 1);
    tick();
    chk("waw_out_op", {out_op, out_rd, out_rd_wen}, {4'h4, 2'd2, 1'b1});
    put(1,2,0,0,0,4'h5,8'h00,8'h00,0,0,8'h00,1);
    chk("waw_set_wins", in_ready, 0);
    tick();
    put(0,0,0,0,0,4'h0,8'h00,8'h00,1,2,8'h67,1); tick();
    put(1,2,0,0,0,4'h5,8'h67,8'h00,0,0,8'h00,1);
    chk("waw_cleared", in_ready, 1);
    tick();

    // reset while busy[1]=1 and out_valid=1
    put(1,0,0,1,1,4'h6,8'h00,8'h00,0,0,8'h00,1); tick();
    chk("rst_pre_valid", out_valid, 1);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    tick();
    chk("rst_out_cleared", {out_valid, out_a, out_op}, 0);
    @(negedge clk);
    reset = 1'b0;
    put(1,1,1,0,0,4'h7,8'h31,8'h32,0,0,8'h00,1);
    chk("rst_busy_cleared", in_ready, 1);
    tick();
    chk("rst_post_out", {out_valid, out_op}, {1'b1, 4'h7});

    // back-to-back independent instructions
    for (int i = 0; i < 8; i++) begin
      put(1,0,0,0,0,4'(i),8'(i),8'(i+16),0,0,8'h00,1);
      chk("b2b_ready", in_ready, 1);
      tick();
      chk("b2b_out", {out_valid, out_op, out_a}, {1'b1, 4'(i), 8'(i)});
    end

    // randomized run against the reference model
    do_reset();
    tbl_mode = 1'b0;
    for (int i = 0; i < NR; i++) rf[i] = 8'($urandom);
    mbusy = '0;
    outq.delete();
    held = '{8'h00, 8'h00, 2'd0, 1'b0, 4'h0};
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rs1    = 2'($urandom); in_rs2 = 2'($urandom); in_rd = 2'($urandom);
      in_rd_wen = $urandom_range(0, 1) == 1;
      in_op     = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_wen    = ($urandom_range(0, 2) == 0);
      wb_addr   = 2'($urandom);
      wb_data   = 8'($urandom);
      #1;
      b1 = BYP && wb_wen && (wb_addr == in_rs1);
      b2 = BYP && wb_wen && (wb_addr == in_rs2);
      hz = (mbusy[in_rs1] && !b1) || (mbusy[in_rs2] && !b2)
        || (in_rd_wen && mbusy[in_rd] && !(wb_wen && wb_addr == in_rd));
      exp_ir = (outq.size() == 0 || out_ready) && !hz;
      chk("rnd_in_ready", in_ready, exp_ir);
      chk("rnd_raddr", {rf_raddr1, rf_raddr2}, {in_rs1, in_rs2});
      acc = in_valid && exp_ir;
      e = '{b1 ? wb_data : rf[in_rs1], b2 ? wb_data : rf[in_rs2], in_rd, in_rd_wen, in_op};
      tick();
      if (outq.size() != 0 && out_ready) void'(outq.pop_front());
      if (acc) begin
        outq.push_back(e);
        held = e;
      end
      if (wb_wen) begin
        rf[wb_addr] = wb_data;
        mbusy[wb_addr] = 1'b0;
      end
      if (acc && e.rdw) mbusy[e.rd] = 1'b1;
      chk("rnd_out_valid", out_valid, outq.size() != 0);
      chk("rnd_out_data", {out_a, out_b, out_rd, out_rd_wen, out_op},
          {held.a, held.b, held.rd, held.rdw, held.op});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Read-side initiator for the 8-bit, 4-entry register file. It drives both read address ports and captures the two operands into a valid/ready pipeline register for the execute stage.
- Tracks writes in flight with a per-register busy scoreboard. Stalls the decoder on RAW/WAW hazards.
- Optionally bypasses same-cycle writeback data, because register file writes land only at the clock edge.

Parameters:
DW, 8, operand/data width (matches register file word)
AW, 2, register address width (2^AW registers)
TW, 4, width of opaque op tag passed through

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
in_valid  in  1  decoder presents an instruction
in_ready  out  1  operand_fetch accepts this cycle
in_rs1  in  AW  source register 1
in_rs2  in  AW  source register 2
in_rd  in  AW  destination register
in_rd_wen  in  1  instruction will write in_rd
in_op  in  TW  opaque tag, passed through
rf_raddr1  out  AW  register file read address A
rf_raddr2  out  AW  register file read address B
rf_rdata1  in  DW  register file read data A (combinational)
rf_rdata2  in  DW  register file read data B (combinational)
wb_wen  in  1  writeback writes register file this cycle
wb_addr  in  AW  writeback register address
wb_data  in  DW  writeback data
out_valid  out  1  operand register holds an instruction
out_ready  in  1  execute stage consumes
out_a  out  DW  operand 1
out_b  out  DW  operand 2
out_rd  out  AW  destination register
out_rd_wen  out  1  destination write flag
out_op  out  TW  tag

Behaviour:
- rf_raddr1 = in_rs1 and rf_raddr2 = in_rs2, combinational and unconditional.
- Scoreboard busy[2^AW]: bit set marks a write pending for that register.
- Hazard = (busy[in_rs1] and not bypassable) OR (busy[in_rs2] and not bypassable) OR (in_rd_wen AND busy[in_rd] AND NOT (wb_wen AND wb_addr == in_rd)).
- Bypassable source: wb_wen AND wb_addr == rs (see optional feature).
- Sources are always checked, even if the instruction does not use them. The decoder supplies a non-busy or same-as-rd value for unused fields.
- in_ready = (NOT out_valid OR out_ready) AND NOT hazard. in_ready does not depend on in_valid.
- Accept = in_valid AND in_ready. On accept, at the next edge:
  - out_valid <= 1.
  - out_a <= bypassed-or-rf_rdata1, out_b likewise from rf_rdata2.
  - out_rd, out_rd_wen and out_op are registered.
- When out_ready AND out_valid without an accept: out_valid <= 0. Output data holds its last value.
- When out_valid AND NOT out_ready: all out_* hold. There is no bubble insertion and no data change while stalled.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 per cycle with no hazards.
- Scoreboard update each edge:
  - wb_wen clears busy[wb_addr]. Writeback to a non-busy register is legal and leaves it clear.
  - Accept with in_rd_wen sets busy[in_rd].
  - Set and clear of the same register in the same cycle: set wins.
- Register x as both rs and rd of one instruction: the source check uses pre-accept busy state, so there is no self-stall.
- Reset: out_valid=0, out_a=out_b=0, out_rd=0, out_rd_wen=0, out_op=0, all busy=0. Any in-flight instruction is discarded. Writebacks arriving after reset do not set busy.
- in_ready reads 0 during reset.

Optional Feature:
OPFETCH_BYPASS_EN
- Defined: a source equal to wb_addr with wb_wen high is not a hazard. Its operand is taken from wb_data instead of rf_rdata. Applies per source independently, and to both sources if they are equal.
- Undefined: bypassable is constant 0. Any busy source stalls through the writeback cycle and issues the next cycle, reading the updated register file. Operands always come from rf_rdata. Scoreboard clear/set rules are unchanged.

Test Plan:
- Reset, then in_valid with rs1=1, rs2=2, rf_rdata=0x11/0x22, out_ready=1 -> next cycle out_valid=1, out_a=0x11, out_b=0x22, out_op passed through; in_ready=1 throughout.
- Issue rd=3, rd_wen=1; next instruction rs1=3 -> in_ready=0 until wb_wen, wb_addr=3, wb_data=0x5A.
  - Bypass on: accepted in the wb cycle, out_a=0x5A.
  - Bypass off: accepted one cycle later with out_a=rf_rdata1.
- out_ready=0 for 3 cycles with out_valid=1 and a new in_valid -> in_ready=0, out_* stable for 3 cycles; out_ready=1 -> new instruction registered the next edge.
- WAW: rd=2 pending, new instruction rd=2, rd_wen=1, sources clear -> stall until wb to 2. Accept in the wb cycle leaves busy[2]=1 (set wins). A later wb to 2 clears it.
- Assert reset while busy[1]=1 and out_valid=1 -> next cycle out_valid=0, busy all 0. Instruction with rs1=1 is accepted immediately after reset deasserts.
- Back-to-back independent instructions for 8 cycles with out_ready=1 -> one output per cycle, in order, and the tag sequence matches the input.
